// File: rtl/digital_lock_gen_if.sv
// Key/command inputs and status outputs of the parametrised digital lock.
// Commands are single-cycle pulses with no back-pressure; status outputs are registered levels (fail_pulse is one cycle wide).
interface digital_lock_gen_if #(
    parameter int NUM_BTN  = 4,
    parameter int CODE_LEN = 4,
    parameter int MAX_FAIL = 3
);
    logic [NUM_BTN-1:0]              btn_pulse;
    logic                            lock_req;
    logic                            prog_req;
    logic                            unlocked;
    logic                            alarm;
    logic                            fail_pulse;
    logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt;
    logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt;
    logic [2:0]                      rgb;
    logic [2:0]                      state_dbg;

    modport master (
        output btn_pulse, lock_req, prog_req,
        input  unlocked, alarm, fail_pulse, digit_cnt, fail_cnt, rgb, state_dbg
    );

    modport slave (
        input  btn_pulse, lock_req, prog_req,
        output unlocked, alarm, fail_pulse, digit_cnt, fail_cnt, rgb, state_dbg
    );
endinterface

// File: rtl/digital_lock_gen.sv
// Parametrised digital lock: code entry with failure lockout, entry timeout,
// optional auto-relock and a programming mode that rewrites the code register.
module digital_lock_gen #(
    parameter int NUM_BTN        = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*$clog2(NUM_BTN)-1:0] DEFAULT_CODE = 8'h21,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1_250_000_000,
    parameter int ENTRY_TIMEOUT  = 625_000_000,
    parameter int RELOCK_CYCLES  = 0
) (
    input  logic                clk,
    input  logic                rst,
    digital_lock_gen_if.slave   bus
);
    localparam int KEY_W   = $clog2(NUM_BTN);
    localparam int DCW     = $clog2(CODE_LEN + 1);
    localparam int FCW     = $clog2(MAX_FAIL + 1);
    localparam int DIDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TMR_A   = (LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT;
    localparam int TMR_MAX = (TMR_A > RELOCK_CYCLES) ? TMR_A : RELOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RELOCK_LAST = (RELOCK_CYCLES > 0) ? RELOCK_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_OPEN    = 3'd2,
        S_PROG    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t                          state;
    logic [CODE_LEN-1:0][KEY_W-1:0]  code;
    logic [CODE_LEN-1:0][KEY_W-1:0]  shadow;
    logic [CODE_LEN-1:0][KEY_W-1:0]  shadow_n;
    logic                            mm;
    logic [DCW-1:0]                  digit_cnt;
    logic [FCW-1:0]                  fail_cnt;
    logic [TMR_W-1:0]                timer;
    logic                            unlocked;
    logic                            alarm;
    logic                            fail_pulse;
    logic [2:0]                      rgb;

    logic                            key_any;
    logic                            key_one;
    logic [KEY_W-1:0]                key_idx;
    logic [DIDX_W-1:0]               dig_idx;
    logic                            digit_mm;
    logic                            seq_mm;
    logic                            last_digit;
    logic                            entry_tmo;

    // Key decode; a multi-key pulse still counts as a digit but can never match.
    always_comb begin
        key_any = |bus.btn_pulse;
        key_one = $onehot(bus.btn_pulse);
        key_idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (bus.btn_pulse[i]) key_idx = KEY_W'(i);
        end
        dig_idx    = DIDX_W'(digit_cnt);
        digit_mm   = !key_one || (key_idx != code[dig_idx]);
        seq_mm     = ((state == S_ENTRY) && mm) || digit_mm;
        last_digit = (digit_cnt == DCW'(CODE_LEN - 1));
        entry_tmo  = (timer == TMR_W'(ENTRY_TIMEOUT - 1));
        shadow_n          = shadow;
        shadow_n[dig_idx] = key_idx;
    end

    function automatic logic [2:0] rgb_of(input state_t s);
        case (s)
            S_ENTRY:   rgb_of = 3'b110;
            S_OPEN:    rgb_of = 3'b010;
            S_PROG:    rgb_of = 3'b001;
            S_LOCKOUT: rgb_of = 3'b100;
            default:   rgb_of = 3'b000;
        endcase
    endfunction

    // Every state entry restarts the shared timer and loads the registered outputs.
    task automatic go(input state_t s);
        state    <= s;
        timer    <= '0;
        unlocked <= (s == S_OPEN) || (s == S_PROG);
        alarm    <= (s == S_LOCKOUT);
        rgb      <= rgb_of(s);
    endtask

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            code       <= DEFAULT_CODE;
            shadow     <= '0;
            mm         <= 1'b0;
            digit_cnt  <= '0;
            fail_cnt   <= '0;
            timer      <= '0;
            unlocked   <= 1'b0;
            alarm      <= 1'b0;
            fail_pulse <= 1'b0;
            rgb        <= 3'b000;
        end else begin
            fail_pulse <= 1'b0;
            if (timer != '1) timer <= timer + TMR_W'(1);
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (key_any) begin
                        if (last_digit) begin
                            digit_cnt <= '0;
                            mm        <= 1'b0;
                            if (!seq_mm) begin
                                go(S_OPEN);
                                fail_cnt <= '0;
                            end else begin
                                fail_pulse <= 1'b1;
                                fail_cnt   <= fail_cnt + FCW'(1);
                                if (fail_cnt == FCW'(MAX_FAIL - 1)) go(S_LOCKOUT);
                                else go(S_IDLE);
                            end
                        end else begin
                            go(S_ENTRY);
                            digit_cnt <= digit_cnt + DCW'(1);
                            mm        <= seq_mm;
                        end
                    end else if (state == S_ENTRY && entry_tmo) begin
                        go(S_IDLE);
                        digit_cnt <= '0;
                        mm        <= 1'b0;
                    end
                end
                S_OPEN: begin
                    if (bus.lock_req) begin
                        go(S_IDLE);
                    end else if (bus.prog_req) begin
                        go(S_PROG);
                        digit_cnt <= '0;
                    end else if (RELOCK_CYCLES > 0 && timer == TMR_W'(RELOCK_LAST)) begin
                        go(S_IDLE);
                    end
                end
                S_PROG: begin
                    if (bus.lock_req) begin
                        go(S_IDLE);
                        digit_cnt <= '0;
                    end else if (key_one) begin
                        timer <= '0;
                        if (last_digit) begin
                            code      <= shadow_n;
                            digit_cnt <= '0;
                            go(S_OPEN);
                        end else begin
                            shadow    <= shadow_n;
                            digit_cnt <= digit_cnt + DCW'(1);
                        end
                    end else if (entry_tmo) begin
                        go(S_OPEN);
                        digit_cnt <= '0;
                    end
                end
                S_LOCKOUT: begin
                    if (timer == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                        go(S_IDLE);
                        fail_cnt <= '0;
                    end
                end
                default: begin
                    go(S_IDLE);
                    digit_cnt <= '0;
                    mm        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.unlocked   = unlocked;
    assign bus.alarm      = alarm;
    assign bus.fail_pulse = fail_pulse;
    assign bus.digit_cnt  = digit_cnt;
    assign bus.fail_cnt   = fail_cnt;
    assign bus.rgb        = rgb;
    assign bus.state_dbg  = state;
endmodule

// File: doc/digital_lock_gen.md
Name: digital_lock_gen

Overview:
Parametrised successor to the fixed 4-button digital lock. It consumes already-debounced, single-cycle button pulses from NUM_BTN keys and matches a CODE_LEN-digit code held in a runtime-programmable register. It adds a failed-attempt counter with timed lockout, an inter-key entry timeout, optional auto-relock, and a code-programming mode. It sits between the per-button debounce/pulse stages and the board LEDs/RGB.

Parameters:
NUM_BTN, 4, number of keys (>=2); KEY_W = $clog2(NUM_BTN) is a derived localparam.
CODE_LEN, 4, digits per code (>=1).
DEFAULT_CODE, 8'h21, reset code, CODE_LEN*KEY_W bits; digit 0 in LSBs (default = keys 1,0,2,0).
MAX_FAIL, 3, consecutive wrong codes that trigger lockout (>=1).
LOCKOUT_CYCLES, 1_250_000_000, lockout duration in clk cycles.
ENTRY_TIMEOUT, 625_000_000, max idle cycles between keys during ENTRY/PROG.
RELOCK_CYCLES, 0, auto-relock delay in OPEN; 0 disables auto-relock.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_pulse  in  NUM_BTN  one-cycle key pulses, bit i = key i
lock_req  in  1  pulse: relock from OPEN
prog_req  in  1  pulse: enter PROG from OPEN
unlocked  out  1  high in OPEN and PROG
alarm  out  1  high in LOCKOUT
fail_pulse  out  1  one-cycle pulse per rejected code
digit_cnt  out  $clog2(CODE_LEN+1)  digits entered in current ENTRY/PROG sequence
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures
rgb  out  3  {R,G,B}: IDLE 000, ENTRY 110, OPEN 010, PROG 001, LOCKOUT 100

Behaviour:
- Reset (async): state IDLE, code register = DEFAULT_CODE, all counters 0, unlocked/alarm/fail_pulse 0, rgb 000.
- Key event = any bit of btn_pulse set. Exactly one bit set -> key index = bit position. More than one bit set -> counted as a digit but always a mismatch (in PROG: ignored, not counted).
- All outputs are registered; state changes take effect the cycle after the triggering pulse (latency 1).
- IDLE: key -> ENTRY, digit_cnt=1, mismatch flag = (key != code[0]).
- ENTRY: each key ORs (key != code[digit_cnt]) into sticky mismatch and increments digit_cnt. Digit number CODE_LEN is evaluated in the same cycle as its key:
  - match -> OPEN, fail_cnt=0.
  - mismatch -> fail_pulse=1 for one cycle, fail_cnt+1; reaching MAX_FAIL -> LOCKOUT, otherwise -> IDLE. digit_cnt returns to 0 in both cases.
- Inter-key timer in ENTRY: cleared on every key. Reaching ENTRY_TIMEOUT -> IDLE, digit_cnt=0; this does not count as a failure.
- OPEN:
  - Keys ignored.
  - lock_req -> IDLE. prog_req -> PROG with digit_cnt=0. Both in the same cycle: lock_req wins.
  - If RELOCK_CYCLES>0, auto-return to IDLE after RELOCK_CYCLES cycles in OPEN.
- PROG: each valid key is written to shadow[digit_cnt]. On digit CODE_LEN, shadow is committed to the code register atomically -> OPEN. lock_req -> IDLE without commit. ENTRY_TIMEOUT since last key -> OPEN without commit.
- LOCKOUT: keys, lock_req and prog_req ignored; alarm=1. After LOCKOUT_CYCLES cycles -> IDLE, fail_cnt=0.
- lock_req/prog_req outside the states above are ignored.
- Counters saturate and never wrap. Timers reset on every state entry.
- Reset mid-operation aborts everything, including any uncommitted PROG shadow. A committed code is lost on reset and returns to DEFAULT_CODE.

Test Plan:
Bench parameters: defaults except ENTRY_TIMEOUT=16, LOCKOUT_CYCLES=32, RELOCK_CYCLES=0.
1. Keys 1,0,2,0 (btn_pulse 0010,0001,0100,0001), 3 idle cycles apart -> unlocked=1 and rgb=010 one cycle after the 4th pulse; fail_cnt=0.
2. Keys 1,0,2,3 -> fail_pulse for exactly 1 cycle, fail_cnt=1, state IDLE, rgb=000. Repeat twice more -> third failure gives alarm=1, rgb=100. Any key during the 32-cycle lockout has no effect. After 32 cycles alarm=0, fail_cnt=0.
3. Keys 1,0 then 16 idle cycles -> digit_cnt=0, rgb=000, fail_cnt unchanged. Then full code 1,0,2,0 -> OPEN.
4. In OPEN, pulse btn_pulse=0011 during entry of the 2nd digit of a fresh attempt -> attempt rejected at digit 4 with fail_pulse; prog_req and lock_req in the same cycle in OPEN -> IDLE.
5. OPEN, prog_req, keys 3,3,2,1 -> back to OPEN. lock_req. Old code 1,0,2,0 fails; new code 3,3,2,1 opens. Assert rst -> DEFAULT_CODE restored, 1,0,2,0 opens again.
6. Assert rst asynchronously mid-ENTRY (digit_cnt=2, fail_cnt=2) -> all outputs 0 before the next clk edge. Next attempt starts from digit_cnt=0, fail_cnt=0.
